constraint_rejection_sampler: RTL and testbench
===============================================

// Module: constraint_rejection_sampler
// PURPOSE
//  Produces random candidate vectors for an external combinational constraint checker (result on sat_i).
//  Candidates the checker accepts are delivered as samples on a valid/ready stream; rejected candidates are discarded.
//  Sits in front of the generated constraint modules as their stimulus/sampling side.
// PARAMETERS
//  VEC_W      185   total candidate width (concatenated checker inputs, LSB = first input)
//  MAX_TRIES  1024  rejections allowed per sample before abort (>=2)
//  CNT_W      16    width of num_samples_i / remaining counter
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      async active-low reset
//  seed_i         in   32     base seed
//  seed_load_i    in   1      load seed into all lanes (IDLE only)
//  start_i        in   1      begin run (IDLE only)
//  num_samples_i  in   CNT_W  samples to produce; 0 = finish immediately
//  cand_o         out  VEC_W  current candidate, drives checker
//  sat_i          in   1      checker verdict for cand_o, same cycle
//  sample_o       out  VEC_W  accepted sample (held stable while valid)
//  sample_valid_o out  1      sample available
//  sample_ready_i in   1      consumer accepts
//  busy_o         out  1      state != IDLE
//  done_o         out  1      1-cycle pulse at end of run
//  timeout_o      out  1      sticky: last run aborted on MAX_TRIES; cleared by start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; lanes = per-lane default seeds; remaining = 0; tries = 0.
//  Generator: NL = ceil(VEC_W/32) 32-bit Galois LFSR lanes, poly 0x80200003; cand_o = lane bits truncated to VEC_W.
//   Lane k seed = seed_i ^ (k*0x9E3779B9); a result of 0 is replaced by 0x1. Lanes advance only in GEN.
//  FSM: IDLE -> GEN on start_i (load remaining = num_samples_i, clear timeout; if 0 -> DONE).
//   GEN: each cycle evaluate sat_i on current cand_o.
//    sat_i=1: sample_o <= cand_o, sample_valid_o <= 1, tries <= 0, -> HOLD.
//    sat_i=0: lanes step, tries++; if tries == MAX_TRIES-1 -> timeout_o <= 1, -> DONE.
//   HOLD: sample_valid_o held; lanes frozen. On valid&&ready: valid <= 0, remaining--;
//    if remaining was 1 -> DONE, else lanes step and -> GEN.
//   DONE: done_o = 1 for one cycle, -> IDLE.
//  Latency: first-try accept -> sample_valid_o one cycle after the GEN cycle with sat_i=1.
//  A sample is never dropped or duplicated; sample_o changes only while sample_valid_o=0.
//  start_i / seed_load_i outside IDLE: ignored. Both set in the same IDLE cycle: seed loads first, run starts with the new seed.
//  sample_ready_i while not valid: no effect.
//  rst_n low mid-run: immediate return to reset state; any pending sample is lost.
//  Counters: remaining counts down (no wrap, exit at 1); tries never exceeds MAX_TRIES-1.
// CONFIGURATION
//  SAMPLER_STATS_EN defined: adds output total_rej_o [31:0], count of rejected candidates since reset.
//   Saturates at 0xFFFFFFFF; not cleared by start; readable at any time.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  sampler_pkg: state enum {IDLE,GEN,HOLD,DONE}, LANE_W=32, LFSR_POLY=32'h80200003,
//   SEED_MIX=32'h9E3779B9, DEFAULT_SEED=32'h1.
//  Sub-module lfsr_lane (32b Galois LFSR: load, step, state out), generated NL times.
// TESTING
//  1 Reset: rst_n=0 -> all outputs 0, busy_o=0; after release cand_o = default-seed lanes.
//  2 Checker tied sat_i=1, num_samples=3, ready=1: 3 handshakes, one per 2 cycles;
//    samples = three consecutive LFSR states; done_o pulses once; timeout_o=0.
//  3 Backpressure: ready=0 for 10 cycles in HOLD -> sample_o and cand_o stable;
//    sample_valid_o stays 1; ready=1 -> exactly one transfer.
//  4 sat_i=0, MAX_TRIES=16: exactly 15 lane steps, then timeout_o=1, done_o pulse,
//    no sample_valid_o; next start clears timeout_o.
//  5 Reference model: checker = (cand_o[3:0]>=4'h4) && (cand_o[15:0]!=16'hb816), seed 0xC0FFEE, 100 samples;
//    every sample satisfies the checker and matches model sequence; same seed twice -> identical stream.
//  6 Edge cases: num_samples=0 -> done_o 1 cycle after start, no sample; start/seed_load while busy ignored;
//    rst_n asserted in HOLD -> valid drops immediately.
//  (SAMPLER_STATS_EN) case 4 run: total_rej_o = 15.

Source files
------------

// File: rtl/constraint_rejection_sampler_pkg.sv
// rtl/constraint_rejection_sampler_pkg.sv - shared types, constants and seed/LFSR helpers for the rejection sampler
package sampler_pkg;

    typedef enum logic [1:0] {IDLE, GEN, HOLD, DONE} state_e;

    localparam int          LANE_W       = 32;
    localparam logic [31:0] LFSR_POLY    = 32'h80200003;
    localparam logic [31:0] SEED_MIX     = 32'h9E3779B9;
    localparam logic [31:0] DEFAULT_SEED = 32'h1;

    // An all-zero Galois state would lock up, so it is remapped to 1.
    function automatic logic [LANE_W-1:0] lane_seed(input logic [31:0] base, input int unsigned k);
        logic [LANE_W-1:0] s;
        s = base ^ (LANE_W'(k) * SEED_MIX);
        return (s == '0) ? LANE_W'(1) : s;
    endfunction

endpackage

// File: rtl/constraint_rejection_sampler_lfsr_lane.sv
// rtl/constraint_rejection_sampler_lfsr_lane.sv - one 32-bit right-shifting Galois LFSR lane with load and step
module lfsr_lane
    import sampler_pkg::*;
#(
    parameter logic [LANE_W-1:0] RESET_SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [LANE_W-1:0] seed_i,
    input  logic              step_i,
    output logic [LANE_W-1:0] state_o
);

    logic [LANE_W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = (state_q >> 1) ^ ({LANE_W{state_q[0]}} & LFSR_POLY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/constraint_rejection_sampler.sv
// rtl/constraint_rejection_sampler.sv - LFSR candidate generator with accept/reject FSM and sample stream
// Optional SAMPLER_STATS_EN adds total_rej_o, a saturating count of rejected candidates since reset.
module constraint_rejection_sampler
    import sampler_pkg::*;
#(
    parameter int VEC_W     = 185,
    parameter int MAX_TRIES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      seed_i,
    input  logic             seed_load_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_samples_i,
    output logic [VEC_W-1:0] cand_o,
    input  logic             sat_i,
    output logic [VEC_W-1:0] sample_o,
    output logic             sample_valid_o,
    input  logic             sample_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o
`ifdef SAMPLER_STATS_EN
    ,
    output logic [31:0]      total_rej_o
`endif
);

    localparam int NL    = (VEC_W + LANE_W - 1) / LANE_W;
    localparam int TRY_W = $clog2(MAX_TRIES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [VEC_W-1:0]   sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;
    logic               lane_load, lane_step;
    logic [NL*LANE_W-1:0] lanes;

    for (genvar k = 0; k < NL; k++) begin : g_lane
        localparam logic [LANE_W-1:0] RST_SEED = lane_seed(DEFAULT_SEED, k);
        logic [LANE_W-1:0] seed_k;
        assign seed_k = lane_seed(seed_i, k);
        lfsr_lane #(.RESET_SEED(RST_SEED)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (lane_load),
            .seed_i  (seed_k),
            .step_i  (lane_step),
            .state_o (lanes[k*LANE_W +: LANE_W])
        );
    end

    if (NL * LANE_W > VEC_W) begin : g_trunc
        logic lanes_unused;
        assign lanes_unused = ^lanes[NL*LANE_W-1:VEC_W];
    end

    assign cand_o = lanes[VEC_W-1:0];

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tries_d     = tries_q;
        sample_d    = sample_q;
        valid_d     = valid_q;
        timeout_d   = timeout_q;
        lane_load   = 1'b0;
        lane_step   = 1'b0;
        case (state_q)
            IDLE: begin
                // Seed lands in the same edge as start, so GEN sees the new lanes.
                lane_load = seed_load_i;
                if (start_i) begin
                    remaining_d = num_samples_i;
                    timeout_d   = 1'b0;
                    tries_d     = '0;
                    state_d     = (num_samples_i == '0) ? DONE : GEN;
                end
            end
            GEN: begin
                if (sat_i) begin
                    sample_d = cand_o;
                    valid_d  = 1'b1;
                    tries_d  = '0;
                    state_d  = HOLD;
                end else begin
                    lane_step = 1'b1;
                    tries_d   = tries_q + TRY_W'(1);
                    if (tries_q == TRY_W'(MAX_TRIES - 2)) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            HOLD: begin
                if (sample_ready_i) begin
                    valid_d     = 1'b0;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        lane_step = 1'b1;
                        state_d   = GEN;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SAMPLER_STATS_EN
    logic [31:0] total_rej_q, total_rej_d;

    always_comb begin
        total_rej_d = total_rej_q;
        if (state_q == GEN && !sat_i && total_rej_q != 32'hFFFF_FFFF) begin
            total_rej_d = total_rej_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_rej_q <= '0;
        end else begin
            total_rej_q <= total_rej_d;
        end
    end

    assign total_rej_o = total_rej_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            tries_q     <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tries_q     <= tries_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign timeout_o      = timeout_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);

endmodule

// File: tb/tb_constraint_rejection_sampler.sv
// tb/tb_constraint_rejection_sampler.sv - randomized self-checking bench with a behavioural sampler model
module tb_constraint_rejection_sampler;

    localparam int VEC_W     = 185;
    localparam int MAX_TRIES = 16;
    localparam int CNT_W     = 16;
    localparam int NL        = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      seed_i = '0;
    logic             seed_load_i = 1'b0;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] num_samples_i = '0;
    logic [VEC_W-1:0] cand_o;
    logic             sat_i;
    logic [VEC_W-1:0] sample_o;
    logic             sample_valid_o;
    logic             sample_ready_i = 1'b0;
    logic             busy_o, done_o, timeout_o;
`ifdef SAMPLER_STATS_EN
    logic [31:0]      total_rej;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int rej_total = 0;
    int sat_mode = 0;
    logic [31:0] m [NL];

    always #5 clk = ~clk;

    function automatic logic chk(input logic [VEC_W-1:0] c);
        return (c[3:0] >= 4'h4) && (c[15:0] != 16'hb816);
    endfunction

    assign sat_i = (sat_mode == 0) ? 1'b0 : (sat_mode == 1) ? 1'b1 : chk(cand_o);

    constraint_rejection_sampler #(.VEC_W(VEC_W), .MAX_TRIES(MAX_TRIES), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .seed_i         (seed_i),
        .seed_load_i    (seed_load_i),
        .start_i        (start_i),
        .num_samples_i  (num_samples_i),
        .cand_o         (cand_o),
        .sat_i          (sat_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
`ifdef SAMPLER_STATS_EN
        .total_rej_o    (total_rej),
`endif
        .timeout_o      (timeout_o)
    );

    task automatic m_seed(input logic [31:0] b);
        for (int k = 0; k < NL; k++) begin
            m[k] = b ^ (32'(k) * 32'h9E3779B9);
            if (m[k] == 32'h0) m[k] = 32'h1;
        end
    endtask

    task automatic m_step();
        for (int k = 0; k < NL; k++) begin
            if (m[k][0]) m[k] = (m[k] >> 1) ^ 32'h80200003;
            else         m[k] = m[k] >> 1;
        end
    endtask

    function automatic logic [VEC_W-1:0] m_cand();
        logic [NL*32-1:0] f;
        for (int k = 0; k < NL; k++) f[k*32 +: 32] = m[k];
        return f[VEC_W-1:0];
    endfunction

    task automatic start_run(input logic [31:0] s, input int n);
        @(negedge clk);
        seed_i        = s;
        seed_load_i   = 1'b1;
        start_i       = 1'b1;
        num_samples_i = CNT_W'(n);
        @(posedge clk);
        #1;
        seed_load_i = 1'b0;
        start_i     = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sample_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (sample_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", sample_valid_o); end
        n_cmp++; if (sample_o !== '0) begin n_bad++; $display("FAIL reset_sample: got %h want 0", sample_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_cmp++; if (timeout_o !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
`ifdef SAMPLER_STATS_EN
        n_cmp++; if (total_rej !== 32'd0) begin n_bad++; $display("FAIL reset_total_rej: got %0d want 0", total_rej); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        m_seed(32'h1);
        n_cmp++; if (cand_o !== m_cand()) begin n_bad++; $display("FAIL reset_cand: got %h want %h", cand_o, m_cand()); end
    endtask

    task automatic test_accept_all();
        logic [VEC_W-1:0] e [3];
        logic [31:0] s;
        int hs, dones, last_c, first_c;
        s = $urandom;
        m_seed(s);
        e[0] = m_cand(); m_step(); e[1] = m_cand(); m_step(); e[2] = m_cand();
        sat_mode = 1;
        sample_ready_i = 1'b1;
        start_run(s, 3);
        hs = 0; dones = 0; last_c = -1; first_c = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (sample_valid_o && sample_ready_i) begin
                if (hs < 3) begin
                    n_cmp++;
                    if (sample_o !== e[hs]) begin n_bad++; $display("FAIL accept_sample%0d: got %h want %h", hs, sample_o, e[hs]); end
                end
                if (hs == 0) first_c = c;
                if (hs > 0) begin
                    n_cmp++;
                    if (c - last_c != 2) begin n_bad++; $display("FAIL accept_spacing: got %0d want 2", c - last_c); end
                end
                last_c = c;
                hs++;
            end
            if (done_o) dones++;
            if (dones > 0 && !busy_o) break;
        end
        n_cmp++; if (first_c != 1) begin n_bad++; $display("FAIL accept_latency: got %0d want 1", first_c); end
        n_cmp++; if (hs != 3) begin n_bad++; $display("FAIL accept_count: got %0d want 3", hs); end
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL accept_done_pulses: got %0d want 1", dones); end
        n_cmp++; if (timeout_o !== 1'b0) begin n_bad++; $display("FAIL accept_timeout: got %b want 0", timeout_o); end
        sample_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] s;
        logic [VEC_W-1:0] s0, c0;
        bit ok, stable_s, stable_c, held_v, saw_done;
        s = $urandom;
        m_seed(s);
        sat_mode = 1;
        sample_ready_i = 1'b0;
        start_run(s, 2);
        wait_valid(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_wait_valid: got 0 want 1"); end
        n_cmp++; if (sample_o !== m_cand()) begin n_bad++; $display("FAIL bp_sample0: got %h want %h", sample_o, m_cand()); end
        s0 = sample_o; c0 = cand_o;
        stable_s = 1; stable_c = 1; held_v = 1;
        repeat (10) begin
            @(negedge clk);
            if (sample_o !== s0) stable_s = 0;
            if (cand_o !== c0) stable_c = 0;
            if (sample_valid_o !== 1'b1) held_v = 0;
        end
        n_cmp++; if (!stable_s) begin n_bad++; $display("FAIL bp_sample_stable: got %h want %h", sample_o, s0); end
        n_cmp++; if (!stable_c) begin n_bad++; $display("FAIL bp_cand_stable: got %h want %h", cand_o, c0); end
        n_cmp++; if (!held_v) begin n_bad++; $display("FAIL bp_valid_held: got %b want 1", sample_valid_o); end
        sample_ready_i = 1'b1;
        @(posedge clk);
        #1 sample_ready_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (sample_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_valid_drop: got %b want 0", sample_valid_o); end
        m_step();
        wait_valid(ok);
        n_cmp++; if (!ok || sample_o !== m_cand()) begin n_bad++; $display("FAIL bp_sample1: got %h want %h", sample_o, m_cand()); end
        sample_ready_i = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_o) begin saw_done = 1; break; end
        end
        n_cmp++; if (!saw_done) begin n_bad++; $display("FAIL bp_done: got 0 want 1"); end
        sample_ready_i = 1'b0;
    endtask

    task automatic test_timeout();
        logic [31:0] s;
        int gen_cycles;
        bit saw_valid, saw_done;
        s = $urandom;
        m_seed(s);
        repeat (MAX_TRIES - 1) m_step();
        sat_mode = 0;
        sample_ready_i = 1'b1;
        start_run(s, 5);
        gen_cycles = 0; saw_valid = 0; saw_done = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (sample_valid_o) saw_valid = 1;
            if (done_o) begin saw_done = 1; break; end
            if (busy_o) gen_cycles++;
        end
        rej_total += MAX_TRIES - 1;
        n_cmp++; if (!saw_done) begin n_bad++; $display("FAIL to_done: got 0 want 1"); end
        n_cmp++; if (timeout_o !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %b want 1", timeout_o); end
        n_cmp++; if (gen_cycles != MAX_TRIES - 1) begin n_bad++; $display("FAIL to_steps: got %0d want %0d", gen_cycles, MAX_TRIES - 1); end
        n_cmp++; if (cand_o !== m_cand()) begin n_bad++; $display("FAIL to_cand: got %h want %h", cand_o, m_cand()); end
        n_cmp++; if (saw_valid) begin n_bad++; $display("FAIL to_no_valid: got 1 want 0"); end
`ifdef SAMPLER_STATS_EN
        n_cmp++; if (total_rej !== 32'(rej_total)) begin n_bad++; $display("FAIL to_total_rej: got %0d want %0d", total_rej, rej_total); end
`endif
        start_run(s, 0);
        @(negedge clk);
        n_cmp++; if (done_o !== 1'b1) begin n_bad++; $display("FAIL to_restart_done: got %b want 1", done_o); end
        n_cmp++; if (timeout_o !== 1'b0) begin n_bad++; $display("FAIL to_cleared: got %b want 0", timeout_o); end
        sample_ready_i = 1'b0;
    endtask

    task automatic test_reference_model();
        logic [VEC_W-1:0] exp_q[$];
        logic [VEC_W-1:0] got_q[$];
        logic [VEC_W-1:0] first_q[$];
        logic [VEC_W-1:0] c;
        bit exp_to, fin, got_to;
        int tries, rej;
        m_seed(32'hC0FFEE);
        exp_to = 0; rej = 0;
        for (int i = 0; i < 100; i++) begin
            tries = 0;
            forever begin
                c = m_cand();
                if (chk(c)) begin exp_q.push_back(c); break; end
                m_step(); tries++; rej++;
                if (tries == MAX_TRIES - 1) begin exp_to = 1; break; end
            end
            if (exp_to) break;
            if (i < 99) m_step();
        end
        sat_mode = 2;
        for (int run = 0; run < 2; run++) begin
            got_q.delete();
            start_run(32'hC0FFEE, 100);
            fin = 0; got_to = 0;
            for (int cyc = 0; cyc < 5000; cyc++) begin
                @(negedge clk);
                sample_ready_i = ($urandom_range(0, 3) != 0);
                if (sample_valid_o && sample_ready_i) got_q.push_back(sample_o);
                if (done_o) begin fin = 1; got_to = timeout_o; break; end
            end
            sample_ready_i = 1'b0;
            rej_total += rej;
            n_cmp++; if (!fin) begin n_bad++; $display("FAIL ref_run%0d_done: got 0 want 1", run); end
            n_cmp++; if (got_to !== exp_to) begin n_bad++; $display("FAIL ref_run%0d_timeout: got %b want %b", run, got_to, exp_to); end
            n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ref_run%0d_count: got %0d want %0d", run, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ref_run%0d_sample%0d: got %h want %h", run, i, got_q[i], exp_q[i]); end
                n_cmp++; if (!chk(got_q[i])) begin n_bad++; $display("FAIL ref_run%0d_sat%0d: got 0 want 1", run, i); end
                if (run == 1 && i < first_q.size()) begin
                    n_cmp++; if (got_q[i] !== first_q[i]) begin n_bad++; $display("FAIL ref_repeat%0d: got %h want %h", i, got_q[i], first_q[i]); end
                end
            end
`ifdef SAMPLER_STATS_EN
            n_cmp++; if (total_rej !== 32'(rej_total)) begin n_bad++; $display("FAIL ref_total_rej: got %0d want %0d", total_rej, rej_total); end
`endif
            if (run == 0) first_q = got_q;
        end
    endtask

    task automatic test_edge_cases();
        logic [31:0] s;
        bit ok, saw_done;
        int done_at;
        start_run($urandom, 0);
        @(negedge clk);
        n_cmp++; if (done_o !== 1'b1) begin n_bad++; $display("FAIL edge_zero_done: got %b want 1", done_o); end
        n_cmp++; if (sample_valid_o !== 1'b0) begin n_bad++; $display("FAIL edge_zero_valid: got %b want 0", sample_valid_o); end
        @(negedge clk);
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL edge_zero_idle: got done=%b busy=%b want 0 0", done_o, busy_o); end

        s = $urandom;
        m_seed(s);
        sat_mode = 1;
        sample_ready_i = 1'b0;
        start_run(s, 1);
        wait_valid(ok);
        @(negedge clk);
        seed_i = ~s; seed_load_i = 1'b1; start_i = 1'b1; num_samples_i = CNT_W'(7);
        @(posedge clk);
        #1 seed_load_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (!ok || sample_o !== m_cand()) begin n_bad++; $display("FAIL edge_busy_sample: got %h want %h", sample_o, m_cand()); end
        n_cmp++; if (cand_o !== m_cand()) begin n_bad++; $display("FAIL edge_busy_seed_ignored: got %h want %h", cand_o, m_cand()); end
        sample_ready_i = 1'b1;
        saw_done = 0; done_at = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_o) begin saw_done = 1; done_at = i; break; end
        end
        sample_ready_i = 1'b0;
        n_cmp++; if (!saw_done || done_at != 0) begin n_bad++; $display("FAIL edge_busy_start_ignored: got done_at=%0d want 0", done_at); end

        start_run(s, 2);
        wait_valid(ok);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (!ok || sample_valid_o !== 1'b0) begin n_bad++; $display("FAIL edge_reset_hold_valid: got %b want 0", sample_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL edge_reset_hold_busy: got %b want 0", busy_o); end
        @(negedge clk);
        rst_n = 1'b1;
        rej_total = 0;
        @(negedge clk);
        m_seed(32'h1);
        n_cmp++; if (cand_o !== m_cand()) begin n_bad++; $display("FAIL edge_reset_cand: got %h want %h", cand_o, m_cand()); end
`ifdef SAMPLER_STATS_EN
        n_cmp++; if (total_rej !== 32'd0) begin n_bad++; $display("FAIL edge_reset_total_rej: got %0d want 0", total_rej); end
`endif
    endtask

    initial begin
        test_reset();
        test_accept_all();
        test_backpressure();
        test_timeout();
        test_reference_model();
        test_edge_cases();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
